ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 156 +++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard frame receiver feeding a scan-code FIFO
//
// Ports:
//   clk         system clock, all state on its rising edge
//   rst         asynchronous active-high reset
//   ps2_clk     raw keyboard clock (asynchronous)
//   ps2_data    raw keyboard data (asynchronous)
//   nextdata_n  active-low pop request, sampled on clk
//   data        scan code at the FIFO head (valid while ready is high)
//   ready       FIFO holds at least one entry
//   overflow    sticky: a good frame was dropped because the FIFO was full
//   frame_err   one-cycle pulse when a completed frame fails its checks

module ps2_rx_fifo #(
    parameter int DEPTH_LOG2  = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    // ------------------------------------------------------------------
    // Input synchronizers. Both chains reset high (PS/2 idle level) so
    // leaving reset never fabricates a falling edge. The data chain is two
    // deep so data_bit is the same age as clk_sync[1], the sample that
    // first shows the clock low.
    // ------------------------------------------------------------------
    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       ps2_fall;
    logic       data_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign ps2_fall = clk_sync[2] & ~clk_sync[1];
    assign data_bit = data_sync[1];

    // ------------------------------------------------------------------
    // Frame capture. Bits enter at the MSB and move down, so after eleven
    // shifts frame[0] is the start bit, frame[8:1] the code, frame[9] the
    // parity and frame[10] the stop bit. frame_done marks the cycle after
    // the eleventh bit, when frame holds the complete frame.
    // ------------------------------------------------------------------
    logic [10:0]     frame;
    logic [3:0]      bit_cnt;
    logic            frame_done;
    logic [TO_W-1:0] to_cnt;
    logic            frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            to_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            if (ps2_fall) begin
                frame  <= {data_bit, frame[10:1]};
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                // Keyboard stalled mid-frame: drop the partial frame silently.
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // Odd parity: the eight data bits plus the parity bit XOR to one.
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    // ------------------------------------------------------------------
    // Scan-code FIFO. One slot is sacrificed so full and empty stay
    // distinguishable with plain DEPTH_LOG2-bit pointers.
    // ------------------------------------------------------------------
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] w_ptr;
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [DEPTH_LOG2-1:0] w_ptr_next;
    logic [DEPTH_LOG2-1:0] r_ptr_next;
    logic                  full;
    logic                  pop;
    logic                  push_req;
    logic                  push;
    logic                  drop;

    always_comb begin
        full       = (w_ptr + PTR_ONE) == r_ptr;
        pop        = ready & ~nextdata_n;
        push_req   = frame_done & frame_ok;
        // A pop in the same cycle frees the slot the push needs.
        push       = push_req & (~full | pop);
        drop       = push_req & full & ~pop;
        w_ptr_next = push ? (w_ptr + PTR_ONE) : w_ptr;
        r_ptr_next = pop  ? (r_ptr + PTR_ONE) : r_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            ready     <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            w_ptr     <= w_ptr_next;
            r_ptr     <= r_ptr_next;
            ready     <= (w_ptr_next != r_ptr_next);
            frame_err <= frame_done & ~frame_ok;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; data is only meaningful while ready is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[w_ptr] <= frame[8:1];
        end
    end

    assign data = mem[r_ptr];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
`timescale 1ns/1ps

module tb_ps2_rx_fifo;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 60;
    localparam int CAP     = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH_LOG2 (3),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         err_exp = 0;
    int         err_seen = 0;
    logic       prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] code, input logic bad);
        return {1'b1, (~^code) ^ bad, code, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            #HALF ps2_clk = 1'b0;
            #HALF ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic settle_check();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ready_after_frame", ready, exp_q.size() > 0);
        chk("overflow", overflow, exp_ovf);
        chk("frame_err_count", err_seen, err_exp);
        if (exp_q.size() > 0) chk("head_data", data, exp_q[0]);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad);
        send_bits(make_frame(code, bad), 11);
        if (bad) err_exp++;
        else if (exp_q.size() < CAP) exp_q.push_back(code);
        else exp_ovf = 1'b1;
        settle_check();
    endtask

    task automatic pop_one();
        @(posedge clk) #1 nextdata_n = 1'b0;
        @(posedge clk) #1 nextdata_n = 1'b1;
        @(negedge clk);
        chk("ready_after_pop", ready, exp_q.size() > 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(posedge clk) #1 rst = 1'b0;
    endtask

    // Monitor: scores every pop the DUT sees and every frame_err pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_err = 1'b0;
        end else begin
            if (prev_err) chk("frame_err_width", frame_err, 0);
            if (frame_err) err_seen++;
            prev_err = frame_err;
            if (!nextdata_n) begin
                if (exp_q.size() == 0) begin
                    chk("pop_empty_ready", ready, 0);
                end else begin
                    chk("pop_ready", ready, 1);
                    chk("pop_data", data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single good frame
        send_frame(8'h1C, 1'b0);
        pop_one();

        // Make / break sequence
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        repeat (3) pop_one();

        // Parity error
        send_frame(8'h5A, 1'b1);

        // Fill past capacity
        for (int c = 1; c <= 8; c++) send_frame(8'(c), 1'b0);
        repeat (8) pop_one();

        // Reset in the middle of a frame, with overflow set beforehand
        send_frame(8'h11, 1'b0);
        for (int c = 0; c < 7; c++) send_frame(8'h40 + 8'(c), 1'b0);
        send_bits(make_frame(8'h77, 1'b0), 6);
        do_reset();
        send_frame(8'h24, 1'b0);
        pop_one();

        // Stalled partial frame is discarded by the timeout
        send_bits(make_frame(8'h33, 1'b0), 5);
        repeat (TIMEOUT + 10) @(posedge clk);
        send_frame(8'h29, 1'b0);
        pop_one();

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            send_frame(8'($urandom), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 1)) pop_one();
        end
        while (exp_q.size() > 0) pop_one();
        pop_one();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
